// File: rtl/column_sense_capture.sv
// rtl/column_sense_capture.sv - column read sequencer: precharge, sense, capture one bit via decoder select lines
//
// Optional feature macro: COL_SELECT_CHECK_EN
//   defined   : col_select is checked (one-hot and matching col_addr); faults set rsp_err and force rsp_data to 0
//   undefined : rsp_err tied to 0, rsp_data taken from bitline[col_addr], col_select ignored
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       column read request handshake, req_addr = column to read
//   col_addr, col_en          address and enable to the column decoder
//   precharge                 bitline precharge strobe
//   col_select                one-hot select lines returned from the decoder
//   bitline                   sensed bitline values, one per column
//   rsp_valid/rsp_ready       response handshake, rsp_data = captured bit, rsp_err = select fault

module column_sense_capture #(
    parameter int ADDR_WIDTH       = 4,
    parameter int NUM_COLS         = 16,
    parameter int PRECHARGE_CYCLES = 1,
    parameter int SENSE_CYCLES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic [ADDR_WIDTH-1:0] col_addr,
    output logic                  col_en,
    output logic                  precharge,
    input  logic [NUM_COLS-1:0]   col_select,
    input  logic [NUM_COLS-1:0]   bitline,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_data,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_SENSE, S_RESP} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       sense_data;
    logic       sense_err;

`ifdef COL_SELECT_CHECK_EN
    logic [ADDR_WIDTH-1:0] sel_idx;
    logic                  sel_onehot;

    // OR-tree encoder: only meaningful when exactly one select bit is set,
    // which the one-hot test below guarantees before the index is trusted.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (col_select[i]) begin
                sel_idx = sel_idx | ADDR_WIDTH'(i);
            end
        end
        sel_onehot = (col_select != '0) &&
                     ((col_select & (col_select - NUM_COLS'(1))) == '0);
        sense_err  = !sel_onehot || (sel_idx != col_addr);
        sense_data = !sense_err && (|(bitline & col_select));
    end
`else
    logic unused_col_select;
    assign unused_col_select = ^col_select;
    assign sense_err         = 1'b0;
    assign sense_data        = bitline[col_addr];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            col_addr  <= '0;
            col_en    <= 1'b0;
            precharge <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        col_addr  <= req_addr;
                        req_ready <= 1'b0;
                        precharge <= 1'b1;
                        cnt       <= 4'(PRECHARGE_CYCLES - 1);
                        state     <= S_PRE;
                    end else begin
                        // first edge after reset raises ready
                        req_ready <= 1'b1;
                    end
                end
                S_PRE: begin
                    if (cnt == 4'd0) begin
                        precharge <= 1'b0;
                        col_en    <= 1'b1;
                        cnt       <= 4'(SENSE_CYCLES - 1);
                        state     <= S_SENSE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_SENSE: begin
                    // bitline/col_select only matter at the final sense edge
                    if (cnt == 4'd0) begin
                        col_en    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= sense_data;
                        rsp_err   <= sense_err;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_column_sense_capture.sv
// tb/tb_column_sense_capture.sv - directed self-checking bench for column_sense_capture

module tb_column_sense_capture;

`ifdef COL_SELECT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_addr, col_addr;
    logic        col_en, precharge;
    logic [15:0] col_select, bitline;
    logic        rsp_valid, rsp_ready, rsp_data, rsp_err;
    logic        sel_force;
    logic [15:0] sel_val;

    logic        req_valid_b, req_ready_b;
    logic [3:0]  col_addr_b;
    logic        col_en_b, precharge_b;
    logic [15:0] col_select_b;
    logic        rsp_valid_b, rsp_ready_b, rsp_data_b, rsp_err_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // decoder model: one-hot select while enabled, or a forced fault pattern
    assign col_select   = sel_force ? sel_val : (col_en ? (16'h0001 << col_addr) : 16'h0000);
    assign col_select_b = col_en_b ? (16'h0001 << col_addr_b) : 16'h0000;

    column_sense_capture dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .col_addr(col_addr), .col_en(col_en),
        .precharge(precharge), .col_select(col_select), .bitline(bitline),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err)
    );

    column_sense_capture #(.PRECHARGE_CYCLES(3), .SENSE_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_addr(req_addr), .col_addr(col_addr_b), .col_en(col_en_b),
        .precharge(precharge_b), .col_select(col_select_b), .bitline(bitline),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b),
        .rsp_err(rsp_err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One read on the default DUT with full cycle-by-cycle timing checks.
    // {precharge, col_en, rsp_valid, req_ready} is checked every cycle.
    task automatic rd(input logic [3:0] a, input logic [15:0] bl, input logic ed,
                      input logic ee, input int stall, input string tag);
        int guard = 0;
        while (!req_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk({tag, " idle_ready"}, req_ready, 1);
        req_addr  = a;
        bitline   = bl;
        req_valid = 1'b1;
        tick();                                   // accept edge T
        req_valid = 1'b0;
        req_addr  = ~a;                           // later changes must not matter
        chk({tag, " T+1 pre"}, {precharge, col_en, rsp_valid, req_ready}, 4'b1000);
        chk({tag, " col_addr"}, col_addr, a);
        tick();
        chk({tag, " T+2 sense"}, {precharge, col_en, rsp_valid, req_ready}, 4'b0100);
        bitline = ~bl;                            // glitch before the final sense edge
        tick();
        chk({tag, " T+3 sense"}, {precharge, col_en, rsp_valid, req_ready}, 4'b0100);
        bitline = bl;
        tick();
        chk({tag, " T+4 resp"}, {precharge, col_en, rsp_valid, req_ready}, 4'b0010);
        chk({tag, " data"}, rsp_data, ed);
        chk({tag, " err"}, rsp_err, ee);
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;
            req_addr  = ~a;
            tick();
            chk($sformatf("%s stall%0d hold", tag, i),
                {precharge, col_en, rsp_valid, req_ready, rsp_data, rsp_err, col_addr},
                {4'b0010, ed, ee, a});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, " done"}, {rsp_valid, req_ready, precharge}, 3'b010);
    endtask

    initial begin
        logic [15:0] one;
        int n_pre, n_en, first_rsp, ovl, seen_rsp;
        logic data_b;

        one         = 16'h0001;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_addr    = 4'd0;
        bitline     = 16'h0000;
        rsp_ready   = 1'b0;
        sel_force   = 1'b0;
        sel_val     = 16'h0000;
        req_valid_b = 1'b0;
        rsp_ready_b = 1'b1;

        // reset values
        tick();
        tick();
        chk("reset outs", {req_ready, col_addr, col_en, precharge, rsp_valid, rsp_data, rsp_err}, 10'd0);
        chk("reset outs b", {req_ready_b, col_en_b, precharge_b, rsp_valid_b}, 4'd0);
        rst = 1'b0;
        tick();
        chk("ready after reset", req_ready, 1);

        // basic reads
        rd(4'd5, 16'h0020, 1'b1, 1'b0, 0, "rd5_one");
        rd(4'd5, 16'hFFDF, 1'b0, 1'b0, 0, "rd5_zero");

        // walking-one sweep
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), one << a, 1'b1, 1'b0, 0, $sformatf("sweep%0d_hit", a));
            rd(4'(a), one << ((a + 1) % 16), 1'b0, 1'b0, 0, $sformatf("sweep%0d_miss", a));
        end

        // response back-pressure with an ignored request
        rd(4'd7, 16'h0080, 1'b1, 1'b0, 10, "stall");

        // select-line faults
        sel_force = 1'b1;
        sel_val   = 16'h0000;
        rd(4'd5, 16'h0020, !CHK, CHK, 0, "sel_zero");
        sel_val   = 16'h0021;
        rd(4'd5, 16'h0020, !CHK, CHK, 0, "sel_multi");
        sel_val   = 16'h0040;
        rd(4'd5, 16'h0020, !CHK, CHK, 0, "sel_wrong");
        sel_force = 1'b0;

        // reset mid-sense
        req_addr  = 4'd5;
        bitline   = 16'h0020;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid col_en", col_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("async drop", {col_en, precharge, rsp_valid, req_ready, col_addr}, 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("reset data", {rsp_data, rsp_err}, 2'd0);
        seen_rsp = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid) seen_rsp++;
        end
        chk("no rsp after reset", seen_rsp, 0);
        chk("ready after mid reset", req_ready, 1);
        rd(4'd10, 16'h0400, 1'b1, 1'b0, 0, "post_reset");

        // long precharge / sense build
        req_addr    = 4'd3;
        bitline     = 16'h0008;
        req_valid_b = 1'b1;
        tick();
        req_valid_b = 1'b0;
        n_pre = 0; n_en = 0; first_rsp = -1; ovl = 0; data_b = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (precharge_b) n_pre++;
            if (col_en_b) n_en++;
            if (precharge_b && col_en_b) ovl++;
            if (rsp_valid_b && first_rsp < 0) begin
                first_rsp = k;
                data_b    = rsp_data_b;
            end
            tick();
        end
        chk("b precharge cycles", n_pre, 3);
        chk("b col_en cycles", n_en, 4);
        chk("b rsp offset", first_rsp, 7);
        chk("b overlap", ovl, 0);
        chk("b data", data_b, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test, required finish");
        $fatal(1, "timeout");
    end

endmodule
